// File: rtl/pl_reset_sequencer_if.sv
// Reset-sequencer signal bundle: lock/request inputs and the staged reset outputs.
// master = the sequencer, slave = whoever drives the requests and consumes the resets.
interface pl_reset_sequencer_if;
    logic        clk_locked;
    logic        ext_resetn;
    logic        interconnect_aresetn;
    logic        peripheral_aresetn;
    logic        peripheral_reset;
    logic        seq_active;
    logic        lock_lost;
    logic [15:0] seq_count;

    modport master (
        input  clk_locked,
        input  ext_resetn,
        output interconnect_aresetn,
        output peripheral_aresetn,
        output peripheral_reset,
        output seq_active,
        output lock_lost,
        output seq_count
    );

    modport slave (
        output clk_locked,
        output ext_resetn,
        input  interconnect_aresetn,
        input  peripheral_aresetn,
        input  peripheral_reset,
        input  seq_active,
        input  lock_lost,
        input  seq_count
    );
endinterface

// File: rtl/pl_reset_sequencer.sv
// PL reset sequencer: waits for a filtered clock lock, holds all resets, then
// releases the interconnect first and the peripherals STAGGER_CYCLES later.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ASSERT     | both resets asserted, counters cleared, one cycle only
// WAIT_LOCK  | resets asserted, counting consecutive qualified cycles
// HOLD       | resets asserted for HOLD_CYCLES after lock qualified
// RELEASE_IC | interconnect released, peripherals still held
// RUN        | everything released; any unqualified cycle aborts
module pl_reset_sequencer #(
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned STAGGER_CYCLES = 4,
    parameter int unsigned LOCK_FILTER    = 3
) (
    input  logic                  pl_clk0,
    input  logic                  reset,
    pl_reset_sequencer_if.master  rst_if
);

    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_HOLD,
        ST_RELEASE_IC,
        ST_RUN
    } state_t;

    // Timers are loaded with N-1 and advance on the cycle they read zero,
    // so the state lasts exactly N cycles.
    localparam logic [15:0] HOLD_LOAD    = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] STAGGER_LOAD = 16'(STAGGER_CYCLES - 1);
    localparam logic [3:0]  FILTER_TC    = 4'(LOCK_FILTER);

    state_t      state_q, state_d;
    logic [1:0]  locked_sync, extn_sync;
    logic        locked_s, extn_s, qualified;
    logic [3:0]  filter_q, filter_d;
    logic [15:0] timer_q, timer_d;
    logic [15:0] seq_count_q, seq_count_d;
    logic        lost_q, lost_d;
    logic        ic_q, ic_d;
    logic        pr_q, pr_d;
    logic        prst_q;
    logic        active_q, active_d;

    assign locked_s  = locked_sync[1];
    assign extn_s    = extn_sync[1];
    assign qualified = locked_s & extn_s;

    // Two-flop synchronizers for the asynchronous lock and reset-request inputs.
    always_ff @(posedge pl_clk0) begin
        if (reset) begin
            locked_sync <= 2'b00;
            extn_sync   <= 2'b00;
        end else begin
            locked_sync <= {locked_sync[0], rst_if.clk_locked};
            extn_sync   <= {extn_sync[0], rst_if.ext_resetn};
        end
    end

    // Next-state, counter and output decode; aborts are checked before timer advance.
    always_comb begin
        state_d     = state_q;
        filter_d    = filter_q;
        timer_d     = timer_q;
        lost_d      = lost_q;
        seq_count_d = seq_count_q;

        case (state_q)
            ST_ASSERT: begin
                filter_d = 4'd0;
                timer_d  = 16'd0;
                state_d  = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (!qualified) begin
                    filter_d = 4'd0;
                end else if (filter_q + 4'd1 == FILTER_TC) begin
                    filter_d = 4'd0;
                    timer_d  = HOLD_LOAD;
                    state_d  = ST_HOLD;
                end else begin
                    filter_d = filter_q + 4'd1;
                end
            end
            ST_HOLD: begin
                if (!qualified) begin
                    timer_d = 16'd0;
                    state_d = ST_ASSERT;
                end else if (timer_q == 16'd0) begin
                    timer_d = STAGGER_LOAD;
                    state_d = ST_RELEASE_IC;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_RELEASE_IC: begin
                if (!qualified) begin
                    timer_d = 16'd0;
                    state_d = ST_ASSERT;
                end else if (timer_q == 16'd0) begin
                    state_d = ST_RUN;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            ST_RUN: begin
                if (!qualified) begin
                    lost_d  = 1'b1;
                    state_d = ST_ASSERT;
                end
            end
            default: state_d = ST_ASSERT;
        endcase

        if (state_d == ST_RUN && state_q != ST_RUN && seq_count_q != 16'hFFFF)
            seq_count_d = seq_count_q + 16'd1;

        ic_d     = (state_d == ST_RELEASE_IC) || (state_d == ST_RUN);
        pr_d     = (state_d == ST_RUN);
        active_d = (state_d != ST_RUN);
    end

    // State, counters and outputs all update on the same edge.
    always_ff @(posedge pl_clk0) begin
        if (reset) begin
            state_q     <= ST_ASSERT;
            filter_q    <= 4'd0;
            timer_q     <= 16'd0;
            seq_count_q <= 16'd0;
            lost_q      <= 1'b0;
            ic_q        <= 1'b0;
            pr_q        <= 1'b0;
            prst_q      <= 1'b1;
            active_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            filter_q    <= filter_d;
            timer_q     <= timer_d;
            seq_count_q <= seq_count_d;
            lost_q      <= lost_d;
            ic_q        <= ic_d;
            pr_q        <= pr_d;
            prst_q      <= ~pr_d;
            active_q    <= active_d;
        end
    end

    assign rst_if.interconnect_aresetn = ic_q;
    assign rst_if.peripheral_aresetn   = pr_q;
    assign rst_if.peripheral_reset     = prst_q;
    assign rst_if.seq_active           = active_q;
    assign rst_if.lock_lost            = lost_q;
    assign rst_if.seq_count            = seq_count_q;

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Directed bench for pl_reset_sequencer at default parameters (16/4/3).
module tb_pl_reset_sequencer;

    logic pl_clk0 = 1'b0;
    logic reset;
    logic mon_en  = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n;

    pl_reset_sequencer_if rif ();

    pl_reset_sequencer #(
        .HOLD_CYCLES   (16),
        .STAGGER_CYCLES(4),
        .LOCK_FILTER   (3)
    ) dut (
        .pl_clk0(pl_clk0),
        .reset  (reset),
        .rst_if (rif.master)
    );

    always #5 pl_clk0 = ~pl_clk0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pl_clk0);
        #1;
    endtask

    // Ticks until the selected release (0 = interconnect, 1 = peripheral) is seen, bounded.
    task automatic wait_rise(input int sel, output int cnt);
        cnt = 0;
        while (cnt < 200 &&
               !((sel == 0) ? rif.interconnect_aresetn : rif.peripheral_aresetn)) begin
            tick();
            cnt++;
        end
    endtask

    task automatic check_outs(input string tag, input logic ic, input logic pr,
                              input logic prst, input logic act, input logic lost,
                              input logic [15:0] cnt);
        chk({tag, "_ic"},    32'(rif.interconnect_aresetn), 32'(ic));
        chk({tag, "_pr"},    32'(rif.peripheral_aresetn),   32'(pr));
        chk({tag, "_prst"},  32'(rif.peripheral_reset),     32'(prst));
        chk({tag, "_act"},   32'(rif.seq_active),           32'(act));
        chk({tag, "_lost"},  32'(rif.lock_lost),            32'(lost));
        chk({tag, "_count"}, 32'(rif.seq_count),            32'(cnt));
    endtask

    // Peripheral must never be out of reset while the interconnect is held.
    always @(negedge pl_clk0) begin
        if (mon_en)
            chk("order", 32'(rif.peripheral_aresetn & ~rif.interconnect_aresetn), 32'd0);
    end

    initial begin
        reset          = 1'b1;
        rif.clk_locked = 1'b1;
        rif.ext_resetn = 1'b1;
        repeat (3) tick();
        check_outs("rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        mon_en = 1'b1;

        // Steady lock from reset release: 2 sync + 3 filter + 16 hold, then 4 stagger.
        reset = 1'b0;
        wait_rise(0, n);
        chk("s1_ic_lat", n, 21);
        chk("s1_ic_pr_held", 32'(rif.peripheral_aresetn), 32'd0);
        wait_rise(1, n);
        chk("s1_pr_lat", n, 4);
        check_outs("s1_run", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);

        // Reset from RUN, then a one-cycle lock glitch restarts the filter (+3 cycles).
        reset          = 1'b1;
        rif.clk_locked = 1'b0;
        tick();
        check_outs("s2_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        reset          = 1'b0;
        rif.clk_locked = 1'b1;
        tick();
        tick();
        rif.clk_locked = 1'b0;
        tick();
        rif.clk_locked = 1'b1;
        wait_rise(0, n);
        chk("s2_ic_lat", n + 3, 24);
        wait_rise(1, n);
        chk("s2_pr_lat", n, 4);
        chk("s2_count", 32'(rif.seq_count), 32'd1);

        // Lock lost in RUN for one cycle: abort two edges later once synchronized.
        rif.clk_locked = 1'b0;
        tick();
        rif.clk_locked = 1'b1;
        tick();
        chk("s3_ic_still", 32'(rif.interconnect_aresetn), 32'd1);
        tick();
        check_outs("s3_abort", 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 16'd1);
        wait_rise(0, n);
        chk("s3_ic_lat", n, 20);
        wait_rise(1, n);
        chk("s3_pr_lat", n, 4);
        chk("s3_count", 32'(rif.seq_count), 32'd2);
        chk("s3_lost", 32'(rif.lock_lost), 32'd1);

        // Three ext_resetn aborts from RUN to bring the count to 5.
        for (int k = 0; k < 3; k++) begin
            rif.ext_resetn = 1'b0;
            tick();
            rif.ext_resetn = 1'b1;
            tick();
            tick();
            chk("pump_abort_ic", 32'(rif.interconnect_aresetn), 32'd0);
            wait_rise(0, n);
            chk("pump_ic_lat", n, 20);
            wait_rise(1, n);
            chk("pump_pr_lat", n, 4);
        end
        chk("pump_count", 32'(rif.seq_count), 32'd5);
        chk("pump_lost", 32'(rif.lock_lost), 32'd1);

        // Reset pulse in RUN clears everything, sequence restarts from scratch.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_outs("s5_rst", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        wait_rise(0, n);
        chk("s5_ic_lat", n, 21);

        // ext_resetn drop while in RELEASE_IC: interconnect re-asserted, no lock_lost.
        rif.ext_resetn = 1'b0;
        tick();
        rif.ext_resetn = 1'b1;
        tick();
        chk("s4_ic_before", 32'(rif.interconnect_aresetn), 32'd1);
        chk("s4_pr_before", 32'(rif.peripheral_aresetn), 32'd0);
        tick();
        check_outs("s4_abort", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);

        // Abort observed on the stagger terminal-count cycle wins over entering RUN.
        wait_rise(0, n);
        chk("s6_ic_lat", n, 20);
        tick();
        rif.ext_resetn = 1'b0;
        tick();
        rif.ext_resetn = 1'b1;
        tick();
        chk("s6_ic_tc", 32'(rif.interconnect_aresetn), 32'd1);
        tick();
        check_outs("s6_abort", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0);
        wait_rise(0, n);
        chk("s6_ic_relat", n, 20);
        wait_rise(1, n);
        chk("s6_pr_lat", n, 4);
        chk("s6_count", 32'(rif.seq_count), 32'd1);

        // Saturation: preload the count just below full, then two more RUN entries.
        force dut.seq_count_q = 16'hFFFE;
        tick();
        tick();
        release dut.seq_count_q;
        tick();
        chk("s7_preload", 32'(rif.seq_count), 32'h0000FFFE);
        for (int k = 0; k < 2; k++) begin
            rif.clk_locked = 1'b0;
            tick();
            rif.clk_locked = 1'b1;
            tick();
            tick();
            wait_rise(0, n);
            chk("s7_ic_lat", n, 20);
            wait_rise(1, n);
            chk("s7_pr_lat", n, 4);
            chk("s7_count_sat", 32'(rif.seq_count), 32'h0000FFFF);
        end
        chk("s7_lost", 32'(rif.lock_lost), 32'd1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
